// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store over valid/ready
// channels, with a programmable request-to-response latency and error reporting.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [7:0]  o_err_count
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [7:0]  r_err_count;

  logic        w_accept;
  logic        w_rsp_hs;
  logic        w_enter_resp;
  logic        w_acc_we;
  logic        w_acc_err;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [3:0]  w_acc_wstrb;
  logic [AW-1:0] w_idx;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign w_accept     = (r_state == IDLE) && i_req_valid;
  assign w_rsp_hs     = (r_state == RESP) && r_rsp_valid && i_rsp_ready;
  assign w_enter_resp = (r_state != RESP) && (w_next_state == RESP);

  // With LATENCY==1 the access happens on the accept edge, before the latch holds the request.
  assign w_acc_we    = (r_state == IDLE) ? i_req_we    : r_we;
  assign w_acc_addr  = (r_state == IDLE) ? i_req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? i_req_wdata : r_wdata;
  assign w_acc_wstrb = (r_state == IDLE) ? i_req_wstrb : r_wstrb;
  assign w_acc_err   = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr >= ADDR_LIMIT);
  assign w_idx       = w_acc_addr[AW+1:2];

  // Next-state and latency counter logic
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_next_state = RESP;
          end else begin
            w_next_state = WAIT;
            w_cnt_next   = CNT_INIT;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (w_rsp_hs) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Request latch, captured on the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
    end else if (w_accept) begin
      r_we    <= i_req_we;
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
      r_wstrb <= i_req_wstrb;
    end
  end

  // Storage array; stores commit on the edge entering RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_enter_resp && w_acc_we && !w_acc_err) begin
      r_mem[w_idx] <= merge_bytes(r_mem[w_idx], w_acc_wdata, w_acc_wstrb);
    end
  end

  // Response channel; rsp_valid trails RESP entry by one edge so the total delay equals LATENCY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_err_count <= 8'd0;
    end else begin
      r_req_ready <= (w_next_state == IDLE);
      r_rsp_valid <= (r_state == RESP) && !w_rsp_hs;
      if (w_enter_resp) begin
        r_rsp_err   <= w_acc_err;
        r_rsp_rdata <= (w_acc_err || w_acc_we) ? 32'd0 : r_mem[w_idx];
      end else if (w_rsp_hs) begin
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= 32'd0;
      end
      if (w_rsp_hs && r_rsp_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_err_count = r_err_count;

endmodule
